barrel_8_bit: RTL and testbench
===============================

// Module: barrel_8_bit
// PURPOSE
//   8-bit barrel shifter with a registered output, used as a datapath utility for
//   byte alignment and shift operations.
//   Shifts an 8-bit operand left or right by 0..7 positions in one pass. Direction
//   is selected per operation. The log2 mux network (stages of 1, 2 and 4) is
//   combinational, and the result is captured in an output register.
// PARAMETERS
//   WIDTH   8  data width; fixed at 8 for this block
//   SHW     3  shift-amount width, log2(WIDTH); fixed at 3
//   ROTATE  0  0 = logical shift with zero fill; 1 = rotate (bits wrap around)
// PORTS
//   clk  input   1  single clock; all state updates on the rising edge
//   rst  input   1  synchronous, active-high reset
//   in   input   8  operand to shift
//   n    input   3  shift amount, 0..7
//   lr   input   1  direction: 1 = left (toward MSB), 0 = right (toward LSB)
//   out  output  8  registered shift result
// BEHAVIOUR
//   - Reset:
//     - rst is synchronous and active-high.
//     - out = 8'h00 on the first rising edge with rst=1, and stays 0 while rst is held.
//     - rst has priority over any shift operation in the same cycle.
//   - Latency:
//     - in, n and lr are sampled on each rising edge when rst=0.
//     - The result appears on out from that edge onward: 1-cycle latency, a new
//       result every cycle, no handshake and no stall.
//   - Datapath: three cascaded mux stages.
//     - Stage 0 shifts by 1 if n[0]=1.
//     - Stage 1 shifts by 2 if n[1]=1.
//     - Stage 2 shifts by 4 if n[2]=1.
//     - Each stage passes data through unchanged when its bit is 0.
//   - Left shift, ROTATE=0: out = (in << n) truncated to 8 bits; vacated LSBs = 0.
//   - Right shift, ROTATE=0: out = in >> n; logical, vacated MSBs = 0, no sign extension.
//   - ROTATE=1:
//     - Left:  out = (in << n) | (in >> (8-n)).
//     - Right: out = (in >> n) | (in << (8-n)).
//   - Boundaries:
//     - n=0 -> out = in, regardless of lr.
//     - n=7 -> only one original bit survives when ROTATE=0.
//     - in=0 -> out=0 for any n and lr.
//   - Changing lr or n between cycles takes effect at the next edge; no history is
//     kept between operations.
//   - Reset asserted mid-stream: the next edge gives out=0. The first edge after
//     rst deasserts registers the current in/n/lr.
//   - No X propagation from the reset state; out is never undefined after the
//     first reset edge.
// TESTING
//   - Reset: rst=1 for 2 cycles with in=8'hFF, n=3, lr=1 -> out=8'h00;
//     release rst -> next edge gives out=8'hF8.
//   - Left, ROTATE=0: in=8'b0000_0011, n=3, lr=1 -> out=8'b0001_1000 one cycle later.
//   - Right, ROTATE=0: in=8'b1011_0000, n=4, lr=0 -> out=8'b0000_1011;
//     in=8'h80, n=7, lr=0 -> out=8'h01.
//   - Pass-through and extremes: in=8'h5A, n=0, lr=0 and lr=1 -> out=8'h5A;
//     in=8'hFF, n=7, lr=1 -> out=8'h80.
//   - ROTATE=1: in=8'h81, n=1, lr=1 -> 8'h03; lr=0 -> 8'hC0;
//     in=8'h01, n=7, lr=0 -> 8'h02.
//   - Sweep: in=1..5, n=0..7, toggle lr every cycle.
//     - Compare out against a golden model delayed by one cycle.
//     - Assert rst mid-sweep -> out=0 next edge, then the sweep resumes correctly.

Source files
------------

// File: rtl/barrel_8_bit.sv
// 8-bit barrel shifter: logical shift or rotate, left/right by 0..7, registered output.
// Latency: 1 cycle (inputs sampled on a rising edge, result on out from that edge).
// Backpressure: none; accepts a new operation every cycle, never stalls.
//
// Ports:
//   clk  - single clock, rising edge
//   rst  - synchronous active-high reset, clears out, overrides any operation
//   in   - 8-bit operand
//   n    - shift amount 0..7
//   lr   - 1 = shift/rotate left (toward MSB), 0 = right (toward LSB)
//   out  - registered result
module barrel_8_bit #(
    parameter int WIDTH  = 8,
    parameter int SHW    = 3,
    parameter bit ROTATE = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in,
    input  logic [SHW-1:0]   n,
    input  logic             lr,
    output logic [WIDTH-1:0] out
);

    // One mux stage: move x by a fixed distance k in the selected direction.
    // With ROTATE the bits pushed off one end re-enter at the other; otherwise
    // the vacated positions are zero-filled (logical, no sign extension).
    function automatic logic [WIDTH-1:0] stage_shift(
        input logic [WIDTH-1:0] x,
        input int               k,
        input logic             left
    );
        logic [WIDTH-1:0] main_part;
        logic [WIDTH-1:0] wrap_part;
        if (left) begin
            main_part = x << k;
            wrap_part = x >> (WIDTH - k);
        end else begin
            main_part = x >> k;
            wrap_part = x << (WIDTH - k);
        end
        if (ROTATE) begin
            return main_part | wrap_part;
        end
        return main_part;
    endfunction

    logic [WIDTH-1:0] w_stage0;
    logic [WIDTH-1:0] w_stage1;
    logic [WIDTH-1:0] w_stage2;
    logic [WIDTH-1:0] r_out;

    // log2 network: stage i moves by 2**i when n[i] is set, else passes through.
    always_comb begin
        w_stage0 = in;
        w_stage1 = in;
        w_stage2 = in;
        w_stage0 = n[0] ? stage_shift(in,       1, lr) : in;
        w_stage1 = n[1] ? stage_shift(w_stage0, 2, lr) : w_stage0;
        w_stage2 = n[2] ? stage_shift(w_stage1, 4, lr) : w_stage1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out <= '0;
        end else begin
            r_out <= w_stage2;
        end
    end

    assign out = r_out;

endmodule

// File: tb/tb_barrel_8_bit.sv
module tb_barrel_8_bit;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] in_d;
    logic [2:0] n_d;
    logic       lr_d;
    logic [7:0] out_shf;
    logic [7:0] out_rot;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    barrel_8_bit #(.ROTATE(1'b0)) u_dut_shf (
        .clk (clk),
        .rst (rst),
        .in  (in_d),
        .n   (n_d),
        .lr  (lr_d),
        .out (out_shf)
    );

    barrel_8_bit #(.ROTATE(1'b1)) u_dut_rot (
        .clk (clk),
        .rst (rst),
        .in  (in_d),
        .n   (n_d),
        .lr  (lr_d),
        .out (out_rot)
    );

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %02h expected %02h", tag, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operand, masked to 8 bits.
    function automatic logic [7:0] ref_model(input logic [7:0] a, input int k,
                                             input bit left, input bit rot);
        int v;
        int r;
        v = a;
        if (left) r = (v << k) | (rot ? (v >> (8 - k)) : 0);
        else      r = (v >> k) | (rot ? (v << (8 - k)) : 0);
        return r[7:0] & 8'hFF;
    endfunction

    // Apply one operation between edges, then check both variants just after the edge.
    task automatic do_op(input bit r, input logic [7:0] a, input logic [2:0] k, input bit l,
                         input logic [7:0] exp_s, input logic [7:0] exp_r, input string tag);
        @(negedge clk);
        rst  = r;
        in_d = a;
        n_d  = k;
        lr_d = l;
        @(posedge clk);
        #1;
        chk({tag, "_shf"}, out_shf, exp_s);
        chk({tag, "_rot"}, out_rot, exp_r);
    endtask

    task automatic do_model(input bit r, input logic [7:0] a, input logic [2:0] k,
                            input bit l, input string tag);
        logic [7:0] es;
        logic [7:0] er;
        es = r ? 8'h00 : ref_model(a, int'(k), l, 1'b0);
        er = r ? 8'h00 : ref_model(a, int'(k), l, 1'b1);
        do_op(r, a, k, l, es, er, tag);
    endtask

    initial begin
        bit l;
        rst  = 1'b1;
        in_d = 8'hFF;
        n_d  = 3'd3;
        lr_d = 1'b1;

        // Reset held two cycles with a non-zero operation pending.
        do_op(1'b1, 8'hFF, 3'd3, 1'b1, 8'h00, 8'h00, "rst_c1");
        do_op(1'b1, 8'hFF, 3'd3, 1'b1, 8'h00, 8'h00, "rst_c2");
        do_op(1'b0, 8'hFF, 3'd3, 1'b1, 8'hF8, 8'hFF, "rst_rel");

        // Directed vectors.
        do_op(1'b0, 8'b0000_0011, 3'd3, 1'b1, 8'b0001_1000, 8'b0001_1000, "left3");
        do_op(1'b0, 8'b1011_0000, 3'd4, 1'b0, 8'b0000_1011, 8'b0000_1011, "right4");
        do_op(1'b0, 8'h80, 3'd7, 1'b0, 8'h01, 8'h01, "right7");
        do_op(1'b0, 8'h5A, 3'd0, 1'b0, 8'h5A, 8'h5A, "pass_r");
        do_op(1'b0, 8'h5A, 3'd0, 1'b1, 8'h5A, 8'h5A, "pass_l");
        do_op(1'b0, 8'hFF, 3'd7, 1'b1, 8'h80, 8'hFF, "left7");
        do_op(1'b0, 8'h81, 3'd1, 1'b1, 8'h02, 8'h03, "rot_l1");
        do_op(1'b0, 8'h81, 3'd1, 1'b0, 8'h40, 8'hC0, "rot_r1");
        do_op(1'b0, 8'h01, 3'd7, 1'b0, 8'h00, 8'h02, "rot_r7");
        do_op(1'b0, 8'h00, 3'd5, 1'b1, 8'h00, 8'h00, "zero_l");
        do_op(1'b0, 8'h00, 3'd6, 1'b0, 8'h00, 8'h00, "zero_r");

        // Sweep in=1..5, n=0..7, lr toggling each cycle, reset injected mid-sweep.
        l = 1'b0;
        for (int a = 1; a <= 5; a++) begin
            for (int k = 0; k < 8; k++) begin
                if (a == 3 && k == 2) begin
                    do_model(1'b1, 8'(a), 3'(k), l, "sweep_rst");
                end
                do_model(1'b0, 8'(a), 3'(k), l, "sweep");
                l = ~l;
            end
        end

        // Randomised operations with occasional reset.
        for (int i = 0; i < 400; i++) begin
            do_model(($urandom_range(0, 19) == 0), 8'($urandom), 3'($urandom_range(0, 7)),
                     1'($urandom), "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
